// File: rtl/instr_word_sequencer_pkg.sv
// Shared ISA definitions for the fetch-side word sequencer: opcode field position,
// the two-word opcode, default width and the sequencer state encoding.
package instr_word_sequencer_pkg;

    localparam int unsigned ISA_WIDTH = 16;
    localparam int unsigned OPC_MSB   = 15;
    localparam int unsigned OPC_LSB   = 11;

    localparam logic [OPC_MSB-OPC_LSB:0] ISA_LONG_OPCODE = 5'b00111;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } iseq_state_e;

endpackage

// File: rtl/iseq_out_reg.sv
// Valid/ready output register for the instruction sequencer: load, hold while
// stalled, clear on drain, and clear on flush regardless of out_ready.
module iseq_out_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_instr,
    input  logic [WIDTH-1:0] ld_imm,
    input  logic             ld_long,
    input  logic [WIDTH-1:0] ld_pc,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_imm,
    output logic             out_long,
    output logic [WIDTH-1:0] out_pc
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             long_q, long_d;
    logic [WIDTH-1:0] pc_q, pc_d;

    // load is only raised when the register is empty or draining, so it never overwrites
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        long_d  = long_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = ld_instr;
            imm_d   = ld_imm;
            long_d  = ld_long;
            pc_d    = ld_pc;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            imm_q   <= '0;
            long_q  <= 1'b0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            long_q  <= long_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_imm   = imm_q;
    assign out_long  = long_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/instr_word_sequencer.sv
// Assembles 16-bit instruction-memory words into whole (instr, imm) issues with PC.
// Optional ISEQ_STATS_EN adds saturating issued/long handshake counters.
module instr_word_sequencer
    import instr_word_sequencer_pkg::*;
#(
    parameter int unsigned                  WIDTH       = ISA_WIDTH,
    parameter logic [WIDTH-1:0]             RESET_PC    = '0,
    parameter logic [OPC_MSB-OPC_LSB:0]     LONG_OPCODE = ISA_LONG_OPCODE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [WIDTH-1:0] flush_pc,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_imm,
    output logic             out_long,
    output logic [WIDTH-1:0] out_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fetch_pc
`ifdef ISEQ_STATS_EN
    ,
    output logic [15:0]      stat_issued,
    output logic [15:0]      stat_long
`endif
);

    iseq_state_e      state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [WIDTH-1:0] hold_pc_q, hold_pc_d;

    logic             accept;
    logic             issue;
    logic [WIDTH-1:0] iss_instr, iss_imm, iss_pc;
    logic             iss_long;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        issue        = 1'b0;
        iss_instr    = in_word;
        iss_imm      = '0;
        iss_long     = 1'b0;
        iss_pc       = fetch_pc_q;
        if (flush) begin
            state_d      = S_OP;
            fetch_pc_d   = flush_pc;
            hold_instr_d = '0;
            hold_pc_d    = '0;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + WIDTH'(1);
            if (state_q == S_IMM) begin
                // second word is pure data: its opcode bits are never inspected
                issue     = 1'b1;
                iss_instr = hold_instr_q;
                iss_imm   = in_word;
                iss_long  = 1'b1;
                iss_pc    = hold_pc_q;
                state_d   = S_OP;
            end else if (in_word[OPC_MSB:OPC_LSB] == LONG_OPCODE) begin
                hold_instr_d = in_word;
                hold_pc_d    = fetch_pc_q;
                state_d      = S_IMM;
            end else begin
                issue = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OP;
            fetch_pc_q   <= RESET_PC;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign fetch_pc = fetch_pc_q;

    iseq_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .load     (issue),
        .ld_instr (iss_instr),
        .ld_imm   (iss_imm),
        .ld_long  (iss_long),
        .ld_pc    (iss_pc),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_imm  (out_imm),
        .out_long (out_long),
        .out_pc   (out_pc)
    );

`ifdef ISEQ_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_long_q, stat_long_d;

    // out_ready is ignored during flush, so a flush-cycle handshake is not counted
    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_long_d   = stat_long_q;
        if (flush) begin
            stat_issued_d = '0;
            stat_long_d   = '0;
        end else if (out_valid && out_ready) begin
            if (stat_issued_q != '1) stat_issued_d = stat_issued_q + 16'd1;
            if (out_long && (stat_long_q != '1)) stat_long_d = stat_long_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_long_q   <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_long_q   <= stat_long_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_long   = stat_long_q;
`endif

endmodule

// File: tb/tb_instr_word_sequencer.sv
// Directed self-checking bench for instr_word_sequencer (default build; ISEQ_STATS_EN
// adds a short counter check).
module tb_instr_word_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] flush_pc;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic        out_long;
    logic [15:0] out_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] fetch_pc;
`ifdef ISEQ_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_long;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // packed view {valid, long, instr, imm, pc}
    logic [49:0] obs, exp_v;

    always #5 clk = ~clk;

    instr_word_sequencer #(
        .WIDTH      (16),
        .RESET_PC   (16'h0000),
        .LONG_OPCODE(5'b00111)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_word  (in_word),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .flush_pc (flush_pc),
        .out_instr(out_instr),
        .out_imm  (out_imm),
        .out_long (out_long),
        .out_pc   (out_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fetch_pc (fetch_pc)
`ifdef ISEQ_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_long  (stat_long)
`endif
    );

    assign obs = {out_valid, out_long, out_instr, out_imm, out_pc};

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; flush = 1'b0; flush_pc = '0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one word presented for one clock; caller checks at the following negedge
    task automatic step_word(input logic [15:0] w);
        in_valid = 1'b1; in_word = w;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        exp_v = {1'b0, 1'b0, 16'h0, 16'h0, 16'h0};
        if (obs !== exp_v || fetch_pc !== 16'h0000) begin
            n_err++; $display("FAIL reset_values got %h/%h exp %h/0000", obs, fetch_pc, exp_v);
        end
        step_word(16'h1111);
        step_word(16'h3800);
        n_vec++;
        if (fetch_pc !== 16'h0002 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL pre_reset_state got pc %h v %b exp 0002 0", fetch_pc, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || fetch_pc !== 16'h0000) begin
            n_err++; $display("FAIL async_reset got v %b pc %h exp 0 0000", out_valid, fetch_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step_word(16'h1234);
        n_vec++;
        exp_v = {1'b1, 1'b0, 16'h1234, 16'h0, 16'h0};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL reset_to_s_op got %h exp %h", obs, exp_v);
        end
    endtask

    task automatic test_short_b2b();
        do_reset();
        in_valid = 1'b1; in_word = 16'h1234;
        @(posedge clk); @(negedge clk);
        in_word = 16'h5678;
        n_vec++;
        exp_v = {1'b1, 1'b0, 16'h1234, 16'h0, 16'h0};
        if (obs !== exp_v || in_ready !== 1'b1) begin
            n_err++; $display("FAIL short0 got %h rdy %b exp %h rdy 1", obs, in_ready, exp_v);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        exp_v = {1'b1, 1'b0, 16'h5678, 16'h0, 16'h1};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL short1 got %h exp %h", obs, exp_v);
        end
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || fetch_pc !== 16'h0002) begin
            n_err++; $display("FAIL short_drain got v %b pc %h exp 0 0002", out_valid, fetch_pc);
        end
    endtask

    task automatic test_long();
        do_reset();
        step_word(16'h3800);
        n_vec++;
        if (out_valid !== 1'b0 || fetch_pc !== 16'h0001) begin
            n_err++; $display("FAIL long_hold got v %b pc %h exp 0 0001", out_valid, fetch_pc);
        end
        step_word(16'h00AB);
        n_vec++;
        exp_v = {1'b1, 1'b1, 16'h3800, 16'h00AB, 16'h0};
        if (obs !== exp_v || fetch_pc !== 16'h0002) begin
            n_err++; $display("FAIL long_issue got %h pc %h exp %h pc 0002", obs, fetch_pc, exp_v);
        end
    endtask

    task automatic test_imm_data();
        do_reset();
        step_word(16'h3800);
        in_valid = 1'b1; in_word = 16'h3FFF;
        @(posedge clk); @(negedge clk);
        in_word = 16'h1000;
        n_vec++;
        exp_v = {1'b1, 1'b1, 16'h3800, 16'h3FFF, 16'h0};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL imm_as_data got %h exp %h", obs, exp_v);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        exp_v = {1'b1, 1'b0, 16'h1000, 16'h0, 16'h2};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL after_imm_short got %h exp %h", obs, exp_v);
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        step_word(16'h1234);
        in_valid = 1'b1; in_word = 16'h5678;
        exp_v = {1'b1, 1'b0, 16'h1234, 16'h0, 16'h0};
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs !== exp_v || in_ready !== 1'b0 || fetch_pc !== 16'h0001) begin
                n_err++; $display("FAIL stall_hold%0d got %h rdy %b pc %h exp %h rdy 0 pc 0001",
                                  i, obs, in_ready, fetch_pc, exp_v);
            end
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        exp_v = {1'b1, 1'b0, 16'h5678, 16'h0, 16'h1};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL stall_release got %h exp %h", obs, exp_v);
        end
    endtask

    task automatic test_flush();
        do_reset();
        step_word(16'h3800);
        flush = 1'b1; flush_pc = 16'h0040; in_valid = 1'b1; in_word = 16'h00AB;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_in_ready got %b exp 0", in_ready);
        end
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || fetch_pc !== 16'h0040) begin
            n_err++; $display("FAIL flush_state got v %b pc %h exp 0 0040", out_valid, fetch_pc);
        end
        step_word(16'h1234);
        n_vec++;
        exp_v = {1'b1, 1'b0, 16'h1234, 16'h0, 16'h0040};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL flush_hold_discard got %h exp %h", obs, exp_v);
        end
        // pending issue must be dropped by flush even with out_ready low
        out_ready = 1'b0; flush = 1'b1; flush_pc = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || fetch_pc !== 16'hFFFF) begin
            n_err++; $display("FAIL flush_drop got v %b pc %h exp 0 ffff", out_valid, fetch_pc);
        end
        step_word(16'h2222);
        n_vec++;
        exp_v = {1'b1, 1'b0, 16'h2222, 16'h0, 16'hFFFF};
        if (obs !== exp_v || fetch_pc !== 16'h0000) begin
            n_err++; $display("FAIL pc_wrap got %h pc %h exp %h pc 0000", obs, fetch_pc, exp_v);
        end
        step_word(16'h3333);
        n_vec++;
        exp_v = {1'b1, 1'b0, 16'h3333, 16'h0, 16'h0000};
        if (obs !== exp_v || fetch_pc !== 16'h0001) begin
            n_err++; $display("FAIL pc_after_wrap got %h pc %h exp %h pc 0001", obs, fetch_pc, exp_v);
        end
    endtask

`ifdef ISEQ_STATS_EN
    task automatic test_stats();
        do_reset();
        step_word(16'h1234);
        step_word(16'h3800);
        step_word(16'h00AB);
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (stat_issued !== 16'd2 || stat_long !== 16'd1) begin
            n_err++; $display("FAIL stats got %0d/%0d exp 2/1", stat_issued, stat_long);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; flush = 1'b0; flush_pc = '0; out_ready = 1'b1;
        test_reset();
        test_short_b2b();
        test_long();
        test_imm_data();
        test_stall();
        test_flush();
`ifdef ISEQ_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
